// File: rtl/bp_update_scheduler_pkg.sv
// Shared types and defaults for the branch-predictor update scheduler.
package bp_update_scheduler_pkg;

    localparam int DEPTH_DEF     = 4;
    localparam int PTR_WIDTH_DEF = 2;
    localparam int CNT_WIDTH_DEF = 32;

    // One resolved-branch update as stored in the FIFO.
    typedef struct packed {
        logic [31:0] pc;
        logic        jump;
    } bp_upd_t;

    // Which requester holds priority for the next contention cycle.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t r);
        return (r == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Dual-push, single-pop circular buffer. When both pushes fire in one
// cycle, entry A lands at tail and entry B at tail+1.
module bp_update_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_WIDTH = PTR_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_a_i,
    input  bp_upd_t              data_a_i,
    input  logic                 push_b_i,
    input  bp_upd_t              data_b_i,
    input  logic                 pop_i,
    output logic [PTR_WIDTH:0]   count_o,
    output bp_upd_t              head_o
);

    localparam int CW = PTR_WIDTH + 1;

    bp_upd_t              mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] head_q, head_d;
    logic [PTR_WIDTH-1:0] tail_q, tail_d;
    logic [PTR_WIDTH-1:0] tail_plus1;
    logic [CW-1:0]        count_q, count_d;
    logic [1:0]           n_push;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        n_push     = {1'b0, push_a_i} + {1'b0, push_b_i};
        tail_plus1 = tail_q + 1'b1;
        tail_d     = tail_q + PTR_WIDTH'(n_push);
        head_d     = pop_i ? (head_q + 1'b1) : head_q;
        count_d    = count_q + CW'(n_push) - CW'(pop_i);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk_i) begin
        if (push_a_i) begin
            mem_q[tail_q] <= data_a_i;
        end
        if (push_b_i) begin
            mem_q[push_a_i ? tail_plus1 : tail_q] <= data_b_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

endmodule

// File: rtl/bp_update_scheduler.sv
// Arbitrates two branch-resolution sources into the predictor's single
// update port. Updates are queued in acceptance order and issued one per
// cycle as a registered pulse; issued/taken counters aid perf debug.
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_WIDTH = PTR_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 a_valid,
    input  logic [31:0]          a_pc,
    input  logic                 a_jump,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [31:0]          b_pc,
    input  logic                 b_jump,
    output logic                 b_ready,
    output logic                 update_control,
    output logic                 update_jump,
    output logic [31:0]          update_pc,
    output logic [CNT_WIDTH-1:0] upd_count,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic                 busy
);

    localparam int CW = PTR_WIDTH + 1;

    logic [CW-1:0]        count;
    logic [CW-1:0]        free;
    bp_upd_t              head;
    bp_upd_t              ent_a;
    bp_upd_t              ent_b;
    logic                 push_a;
    logic                 push_b;
    logic                 pop;
    logic                 contention;

    req_id_t              prio_q, prio_d;
    logic                 upd_ctrl_q, upd_ctrl_d;
    logic                 upd_jump_q, upd_jump_d;
    logic [31:0]          upd_pc_q, upd_pc_d;
    logic [CNT_WIDTH-1:0] upd_cnt_q, upd_cnt_d;
    logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

    assign ent_a = '{pc: a_pc, jump: a_jump};
    assign ent_b = '{pc: b_pc, jump: b_jump};

    // Free space is taken from the registered count only, so a pop in the
    // same cycle never makes room for a push.
    assign free = CW'(DEPTH) - count;

    // Acceptance: with two or more slots both ports fit; with exactly one
    // slot the priority holder wins if both are asking.
    always_comb begin
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        contention = 1'b0;
        if (rdy_in) begin
            a_ready    = (free >= CW'(2)) ||
                         ((free == CW'(1)) && (!b_valid || (prio_q == REQ_A)));
            b_ready    = (free >= CW'(2)) ||
                         ((free == CW'(1)) && (!a_valid || (prio_q == REQ_B)));
            contention = (free == CW'(1)) && a_valid && b_valid;
        end
    end

    assign push_a = a_valid && a_ready;
    assign push_b = b_valid && b_ready;
    assign pop    = rdy_in && (count != '0);

    bp_update_fifo #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .push_a_i (push_a),
        .data_a_i (ent_a),
        .push_b_i (push_b),
        .data_b_i (ent_b),
        .pop_i    (pop),
        .count_o  (count),
        .head_o   (head)
    );

    // Priority flips only when the single free slot was actually contested.
    always_comb begin
        prio_d = prio_q;
        if (contention) begin
            prio_d = other_req(prio_q);
        end
    end

    // Issue stage: latch the head entry and bump counters on each pop.
    always_comb begin
        upd_ctrl_d  = 1'b0;
        upd_jump_d  = upd_jump_q;
        upd_pc_d    = upd_pc_q;
        upd_cnt_d   = upd_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (pop) begin
            upd_ctrl_d  = 1'b1;
            upd_jump_d  = head.jump;
            upd_pc_d    = head.pc;
            upd_cnt_d   = upd_cnt_q + 1'b1;
            taken_cnt_d = taken_cnt_q + CNT_WIDTH'(head.jump);
        end
    end

    // Priority, issue and statistics registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prio_q      <= REQ_A;
            upd_ctrl_q  <= 1'b0;
            upd_jump_q  <= 1'b0;
            upd_pc_q    <= '0;
            upd_cnt_q   <= '0;
            taken_cnt_q <= '0;
        end else begin
            prio_q      <= prio_d;
            upd_ctrl_q  <= upd_ctrl_d;
            upd_jump_q  <= upd_jump_d;
            upd_pc_q    <= upd_pc_d;
            upd_cnt_q   <= upd_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign update_control = upd_ctrl_q;
    assign update_jump    = upd_jump_q;
    assign update_pc      = upd_pc_q;
    assign upd_count      = upd_cnt_q;
    assign taken_count    = taken_cnt_q;
    assign busy           = (count != '0) || upd_ctrl_q;

endmodule
